// File: rtl/rominit_ctrl.sv
// rominit_ctrl: routes host download bytes (ioctl stream) into the boot, chr or
// cartridge ROM of the console core. It holds the core in reset while a download
// is in progress and for RST_HOLD cycles afterwards. It also tracks image
// completeness and a sticky protocol/range error flag.
module rominit_ctrl #(
  parameter int CART_AW  = 17,
  parameter int RST_HOLD = 16
) (
  input  logic               CLK,
  input  logic               RESB,
  input  logic               IOCTL_DOWNLOAD,
  input  logic [7:0]         IOCTL_INDEX,
  input  logic               IOCTL_WR,
  input  logic [24:0]        IOCTL_ADDR,
  input  logic [7:0]         IOCTL_DOUT,
  output logic               IOCTL_WAIT,
  output logic               ROMINIT_SEL_BOOT,
  output logic               ROMINIT_SEL_CHR,
  output logic               ROMINIT_SEL_CART,
  output logic [CART_AW-1:0] ROMINIT_ADDR,
  output logic [7:0]         ROMINIT_DATA,
  output logic               ROMINIT_VALID,
  input  logic               ROMINIT_READY,
  output logic               CORE_RESB,
  output logic               BOOT_OK,
  output logic               CART_OK,
  output logic               ERR
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam int            HW        = $clog2(RST_HOLD + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD - 1);
  localparam int            CW        = CART_AW + 1;

  localparam logic [12:0] BOOT_FULL = 13'd4096;
  localparam logic [10:0] CHR_FULL  = 11'd1024;

  logic [1:0]    state;
  logic [HW-1:0] hold_cnt;
  logic [7:0]    idx_q;

  logic [12:0]   boot_cnt;
  logic [10:0]   chr_cnt;
  logic [CW-1:0] cart_cnt;

  logic               dec_boot;
  logic               dec_chr;
  logic               dec_cart;
  logic               dec_bad;
  logic [CART_AW-1:0] dec_addr;

  logic enter_load;
  logic load_exit;
  logic wr_in_load;
  logic accept;
  logic range_err;
  logic xfer_done;
  logic xfer_viol;

  // Saturating counter increments: a runaway stream must never wrap back to
  // a count that looks like a complete image.
  function automatic logic [12:0] sat_inc_boot(input logic [12:0] v);
    return (v == 13'h1FFF) ? v : v + 13'd1;
  endfunction

  function automatic logic [10:0] sat_inc_chr(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [CW-1:0] sat_inc_cart(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  // Address decode of the incoming byte against the image selected at session start
  always_comb begin
    dec_boot = 1'b0;
    dec_chr  = 1'b0;
    dec_cart = 1'b0;
    dec_bad  = 1'b0;
    dec_addr = '0;
    case (idx_q)
      8'd0: begin
        if (IOCTL_ADDR < 25'h1000) begin
          dec_boot = 1'b1;
          dec_addr = {{(CART_AW-12){1'b0}}, IOCTL_ADDR[11:0]};
        end else if (IOCTL_ADDR < 25'h1400) begin
          dec_chr  = 1'b1;
          dec_addr = {{(CART_AW-10){1'b0}}, IOCTL_ADDR[9:0]};
        end else begin
          dec_bad  = 1'b1;
        end
      end
      8'd1: begin
        if ((IOCTL_ADDR >> CART_AW) == 25'd0) begin
          dec_cart = 1'b1;
          dec_addr = IOCTL_ADDR[CART_AW-1:0];
        end else begin
          dec_bad  = 1'b1;
        end
      end
      default: begin
        // Unknown images are dropped without flagging an error.
      end
    endcase
  end

  // Control events shared by the FSM, datapath and status blocks
  always_comb begin
    enter_load = ((state == ST_IDLE) || (state == ST_HOLD)) && IOCTL_DOWNLOAD;
    load_exit  = (state == ST_LOAD) && !IOCTL_DOWNLOAD;
    wr_in_load = (state == ST_LOAD) && IOCTL_DOWNLOAD && IOCTL_WR;
    accept     = wr_in_load && (dec_boot || dec_chr || dec_cart);
    range_err  = wr_in_load && dec_bad;
    xfer_done  = (state == ST_XFER) && ROMINIT_READY;
    xfer_viol  = (state == ST_XFER) && IOCTL_WR;
  end

  // Session FSM and core reset sequencing; a completed write always returns
  // through LOAD so a falling DOWNLOAD is evaluated after the final count update
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state     <= ST_HOLD;
      hold_cnt  <= HOLD_INIT;
      idx_q     <= 8'd0;
      CORE_RESB <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (IOCTL_DOWNLOAD) begin
            state     <= ST_LOAD;
            idx_q     <= IOCTL_INDEX;
            CORE_RESB <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (!IOCTL_DOWNLOAD) begin
            state    <= ST_HOLD;
            hold_cnt <= HOLD_INIT;
          end else if (accept) begin
            state    <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (ROMINIT_READY) begin
            state <= ST_LOAD;
          end
        end
        ST_HOLD: begin
          if (IOCTL_DOWNLOAD) begin
            state <= ST_LOAD;
            idx_q <= IOCTL_INDEX;
          end else if (hold_cnt == '0) begin
            state     <= ST_IDLE;
            CORE_RESB <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        default: begin
          state <= ST_HOLD;
        end
      endcase
    end
  end

  // Target write request: latched on a decoded byte, held until READY
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      ROMINIT_SEL_BOOT <= 1'b0;
      ROMINIT_SEL_CHR  <= 1'b0;
      ROMINIT_SEL_CART <= 1'b0;
      ROMINIT_ADDR     <= '0;
      ROMINIT_DATA     <= 8'd0;
      ROMINIT_VALID    <= 1'b0;
      IOCTL_WAIT       <= 1'b0;
    end else if (accept) begin
      ROMINIT_SEL_BOOT <= dec_boot;
      ROMINIT_SEL_CHR  <= dec_chr;
      ROMINIT_SEL_CART <= dec_cart;
      ROMINIT_ADDR     <= dec_addr;
      ROMINIT_DATA     <= IOCTL_DOUT;
      ROMINIT_VALID    <= 1'b1;
      IOCTL_WAIT       <= 1'b1;
    end else if (xfer_done) begin
      ROMINIT_SEL_BOOT <= 1'b0;
      ROMINIT_SEL_CHR  <= 1'b0;
      ROMINIT_SEL_CART <= 1'b0;
      ROMINIT_VALID    <= 1'b0;
      IOCTL_WAIT       <= 1'b0;
    end
  end

  // Region byte counters; cleared per image at session entry
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      boot_cnt <= 13'd0;
      chr_cnt  <= 11'd0;
      cart_cnt <= '0;
    end else if (enter_load) begin
      if (IOCTL_INDEX == 8'd0) begin
        boot_cnt <= 13'd0;
        chr_cnt  <= 11'd0;
      end
      if (IOCTL_INDEX == 8'd1) begin
        cart_cnt <= '0;
      end
    end else if (xfer_done) begin
      if (ROMINIT_SEL_BOOT) boot_cnt <= sat_inc_boot(boot_cnt);
      if (ROMINIT_SEL_CHR)  chr_cnt  <= sat_inc_chr(chr_cnt);
      if (ROMINIT_SEL_CART) cart_cnt <= sat_inc_cart(cart_cnt);
    end
  end

  // Image status and sticky error flag
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      BOOT_OK <= 1'b0;
      CART_OK <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      if (enter_load) begin
        ERR <= 1'b0;
        if (IOCTL_INDEX == 8'd0) BOOT_OK <= 1'b0;
        if (IOCTL_INDEX == 8'd1) CART_OK <= 1'b0;
      end else if (range_err || xfer_viol) begin
        ERR <= 1'b1;
      end
      if (xfer_done && ROMINIT_SEL_CART) begin
        CART_OK <= 1'b1;
      end
      if (load_exit && (idx_q == 8'd0)) begin
        BOOT_OK <= (boot_cnt == BOOT_FULL) && (chr_cnt == CHR_FULL);
      end
    end
  end

endmodule

// File: doc/rominit_ctrl.md
ROMINIT_CTRL -- requirements
Module: rominit_ctrl

Interface
REQ-001 Parameter CART_AW, default 17, cartridge ROM address width (128 KiB max).
REQ-002 Parameter RST_HOLD, default 16, core-reset hold cycles after download end (>=1).
REQ-003 CLK  in  1  system clock; all logic on its rising edge.
REQ-004 RESB  in  1  asynchronous, active-low reset.
REQ-005 IOCTL_DOWNLOAD  in  1  download session active (level).
REQ-006 IOCTL_INDEX  in  8  image selector: 0 = boot+chr, 1 = cartridge, other = ignored.
REQ-007 IOCTL_WR  in  1  one-cycle byte strobe.
REQ-008 IOCTL_ADDR  in  25  byte offset within the image.
REQ-009 IOCTL_DOUT  in  8  byte data.
REQ-010 IOCTL_WAIT  out  1  stall to host, high while a byte is pending.
REQ-011 ROMINIT_SEL_BOOT / ROMINIT_SEL_CHR / ROMINIT_SEL_CART  out  1 each  one-hot target select.
REQ-012 ROMINIT_ADDR  out  CART_AW  target address (boot [11:0], chr [9:0], upper bits zero).
REQ-013 ROMINIT_DATA  out  8  target data.
REQ-014 ROMINIT_VALID  out  1  write request to selected target.
REQ-015 ROMINIT_READY  in  1  target accepts write this cycle.
REQ-016 CORE_RESB  out  1  active-low reset to the console core.
REQ-017 BOOT_OK  out  1  full boot (4096 B) and chr (1024 B) image loaded.
REQ-018 CART_OK  out  1  at least one cartridge byte loaded.
REQ-019 ERR  out  1  sticky protocol/range error.

Function
REQ-020 States IDLE, LOAD, XFER, HOLD, fully registered; all outputs registered.
REQ-021 IDLE: CORE_RESB=1, VALID=0, WAIT=0; IOCTL_DOWNLOAD=1 -> LOAD.
REQ-022 Entry to LOAD from IDLE or HOLD clears ERR; index 0 also clears BOOT_OK and boot/chr counters; index 1 also clears CART_OK and cart counter.
REQ-023 LOAD/XFER/HOLD: CORE_RESB=0.
REQ-024 LOAD, IOCTL_WR=1: latch addr/data, decode: index 0 addr<0x1000 -> BOOT; 0x1000..0x13FF -> CHR (addr[9:0]); index 1 addr<2^CART_AW -> CART; next cycle VALID=1, WAIT=1, one SEL high, state XFER.
REQ-025 LOAD, index 0/1 addr out of range: byte dropped, ERR=1, stay LOAD; other index: byte dropped silently.
REQ-026 XFER: ADDR/DATA/SEL held stable while VALID=1; cycle with READY=1 completes write: next cycle VALID=0, WAIT=0, SEL all 0, increment region counter, -> LOAD.
REQ-027 XFER: IOCTL_WR=1 is a violation: byte ignored, ERR=1.
REQ-028 IOCTL_DOWNLOAD=0 in LOAD -> HOLD; in XFER the pending write completes first, then HOLD.
REQ-029 On LOAD->HOLD with index 0: BOOT_OK=1 iff boot count==4096 and chr count==1024 (13-bit/11-bit counters, saturating); duplicate addresses count again (ERR not set).
REQ-030 CART_OK=1 on first completed cart write.
REQ-031 HOLD: counter loads RST_HOLD-1, decrements; at 0 -> IDLE; IOCTL_DOWNLOAD=1 in HOLD -> LOAD immediately.
REQ-032 READY ignored outside XFER.

Reset
REQ-033 RESB=0 async: state HOLD, hold counter RST_HOLD-1, CORE_RESB=0, VALID=0, WAIT=0, SEL all 0, ADDR=0, DATA=0, BOOT_OK=0, CART_OK=0, ERR=0, counters 0.
REQ-034 Reset mid-XFER aborts the pending write; no counter update.
REQ-035 After RESB deasserts with DOWNLOAD=0, CORE_RESB rises exactly RST_HOLD cycles later.

Verification
REQ-036 Reset release, DOWNLOAD=0 -> CORE_RESB=0 for 16 cycles, then 1; all other outputs at reset values.
REQ-037 Index 0, WR addr 0x0FFF data 0xA5, READY low 3 cycles -> SEL_BOOT=1, ADDR=0x0FFF, DATA=0xA5, VALID and WAIT high 4 cycles, drop cycle after READY.
REQ-038 Index 0, full 0x0000..0x13FF stream, READY tied 1 -> 4096 boot + 1024 chr writes, BOOT_OK=1 after DOWNLOAD falls, ERR=0; stream of 0x13FF bytes -> BOOT_OK=0.
REQ-039 Index 0 WR addr 0x1400; WR during XFER -> no VALID for dropped bytes, ERR=1; new download clears ERR.
REQ-040 Index 1 addr 0x1FFFF data 0x3C -> SEL_CART=1, ADDR=0x1FFFF, CART_OK=1; addr 0x20000 -> ERR=1.
REQ-041 DOWNLOAD falls in XFER with READY low 5 cycles -> write completes, then HOLD 16 cycles, CORE_RESB=1; DOWNLOAD re-asserted during HOLD -> LOAD, CORE_RESB stays 0.
